// File: rtl/btn_cond.sv
// btn_cond: five-channel push-button conditioner.
// Each raw button goes through a 2-flop synchroniser and a counter-based
// debouncer. Accepted presses give a single-cycle pulse. The centre button
// also gives a single long-press pulse after LONG_CYC hold cycles.
// Optional feature macro: BTN_REPEAT_EN. When it is defined, the up and down
// channels also auto-repeat: a first pulse after REP_DLY hold cycles, then one
// every REP_PER cycles while the button is held. When it is undefined, no
// repeat logic is built.
// Channel index map (matches btn_lvl): 4 = centre, 3 = left, 2 = right,
// 1 = up, 0 = down.
module btn_cond #(
    parameter int unsigned DB_CYC   = 2000000,
    parameter int unsigned LONG_CYC = 150000000,
    parameter int unsigned REP_DLY  = 50000000,
    parameter int unsigned REP_PER  = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    input  logic       l_bt,
    input  logic       r_bt,
    input  logic       u_bt,
    input  logic       d_bt,
    output logic       bt_p,
    output logic       l_p,
    output logic       r_p,
    output logic       u_p,
    output logic       d_p,
    output logic       bt_long,
    output logic [4:0] btn_lvl,
    output logic       any_p
);

    localparam int unsigned NCH  = 5;
    localparam int unsigned CH_C = 4;

    // The debounce counter only has to reach DB_CYC-1 before the toggle.
    localparam int unsigned DB_W = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    // The hold counter must pass every threshold compared against it, and
    // then saturate strictly above it, so each equality fires once per press.
    localparam int unsigned HOLD_MAX_A = (LONG_CYC > REP_DLY) ? LONG_CYC : REP_DLY;
    localparam int unsigned HOLD_MAX   = (HOLD_MAX_A > REP_PER) ? HOLD_MAX_A : REP_PER;
    localparam int unsigned HOLD_W     = $clog2(HOLD_MAX + 2);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [HOLD_W-1:0] LONG_V   = HOLD_W'(LONG_CYC);

`ifdef BTN_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REP_PER + 1);
    localparam logic [HOLD_W-1:0] REP_DLY_V = HOLD_W'(REP_DLY);
    localparam logic [REP_W-1:0]  REP_PER_V = REP_W'(REP_PER);
`endif

    logic [NCH-1:0]    raw;
    logic [NCH-1:0]    sync1_q;
    logic [NCH-1:0]    sync2_q;
    logic [NCH-1:0]    lvl_v;
    logic [NCH-1:0]    pulse_v;
    logic [HOLD_W-1:0] hold_c;
    logic              long_q;
    logic              long_d;

    assign raw = {bt, l_bt, r_bt, u_bt, d_bt};

    // Two-flop synchroniser on every raw input; nothing else sees raw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic              lvl_q;
        logic              lvl_d;
        logic [DB_W-1:0]   db_q;
        logic [DB_W-1:0]   db_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              press_hit;
        logic              rep_hit;
        logic              pulse_q;
        logic              pulse_d;

        // Debounce: count cycles of disagreement, flip the level on the
        // DB_CYC-th one, and restart the count whenever input and level agree.
        always_comb begin
            lvl_d = lvl_q;
            db_d  = '0;
            if (sync2_q[i] != lvl_q) begin
                if (db_q == DB_LAST) begin
                    lvl_d = !lvl_q;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        end

        // Hold counter: zero in the cycle right after a press is accepted,
        // counts up while held, saturates, and clears once the level drops.
        always_comb begin
            hold_d = '0;
            if (lvl_q) begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
            end
        end

        // A set level with a zero hold count only occurs in the cycle right
        // after acceptance, so this marks each new press exactly once.
        assign press_hit = lvl_q && (hold_q == '0);

`ifdef BTN_REPEAT_EN
        if (i < 2) begin : g_rep
            logic [REP_W-1:0] rep_q;
            logic [REP_W-1:0] rep_d;
            logic             act_q;
            logic             act_d;
            logic             hit;

            // Auto-repeat: first hit at REP_DLY hold cycles. After that, the
            // period counter takes over, because the hold counter saturates.
            always_comb begin
                hit   = lvl_q && ((hold_q == REP_DLY_V) || (act_q && (rep_q == REP_PER_V)));
                rep_d = rep_q;
                act_d = act_q;
                if (!lvl_q) begin
                    rep_d = '0;
                    act_d = 1'b0;
                end else if (hit) begin
                    rep_d = REP_W'(1);
                    act_d = 1'b1;
                end else if (act_q) begin
                    rep_d = rep_q + 1'b1;
                end
            end

            // Repeat period state.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rep_q <= '0;
                    act_q <= 1'b0;
                end else begin
                    rep_q <= rep_d;
                    act_q <= act_d;
                end
            end

            assign rep_hit = hit;
        end else begin : g_norep
            assign rep_hit = 1'b0;
        end
`else
        assign rep_hit = 1'b0;
`endif

        assign pulse_d = press_hit | rep_hit;

        // Per-channel debounce, hold and pulse registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lvl_q   <= 1'b0;
                db_q    <= '0;
                hold_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                lvl_q   <= lvl_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                pulse_q <= pulse_d;
            end
        end

        assign lvl_v[i]   = lvl_q;
        assign pulse_v[i] = pulse_q;

        if (i == CH_C) begin : g_centre
            assign hold_c = hold_q;
        end
    end

    // The hold counter passes LONG_CYC only once per press, so this fires once.
    always_comb begin
        long_d = lvl_v[CH_C] && (hold_c == LONG_V);
    end

    // Long-press pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_q <= 1'b0;
        end else begin
            long_q <= long_d;
        end
    end

    assign btn_lvl = lvl_v;
    assign bt_p    = pulse_v[4];
    assign l_p     = pulse_v[3];
    assign r_p     = pulse_v[2];
    assign u_p     = pulse_v[1];
    assign d_p     = pulse_v[0];
    assign bt_long = long_q;
    assign any_p   = |pulse_v;

endmodule
